// File: rtl/sid_pkg.sv
// sid_pkg: definitions shared by the SID combined-waveform arbiter and the
// blocks around it.
//   state_t    : arbiter sequencer states (IDLE, issue slots S0..S2, drain S3)
//   NUM_VOICES : number of voices served per lookup round
//   ROM_LAT    : read latency of the shared waveform table, in clocks
package sid_pkg;

  localparam int NUM_VOICES = 3;
  localparam int ROM_LAT    = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4
  } state_t;

endpackage

// File: rtl/sid_wave_arbiter_if.sv
// sid_wave_arbiter_if: read bus between the arbiter and the shared
// single-port waveform table.
//   rom_addr : table address, driven by the arbiter
//   rom_data : table read data, registered one clock after rom_addr
// Modports: master = arbiter side, slave = table side.
interface sid_wave_arbiter_if #(
  parameter int IDX_W = 12,
  parameter int DAT_W = 8
);

  logic [IDX_W-1:0] rom_addr;
  logic [DAT_W-1:0] rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);

endinterface

// File: rtl/sid_wave_arbiter.sv
// sid_wave_arbiter: time-multiplexes one shared combined-waveform table
// among three voices. A sample_en strobe snapshots the three indices and
// the voice enables, issues one table read per voice (S0..S2), drains the
// last read (S3), then updates all three outputs together with a done pulse.
// A strobe that arrives mid-round is remembered once (pending); a second
// one is dropped and flagged in the sticky overrun bit.
// Ports:
//   clock, reset_n      : clock, asynchronous active-low reset
//   sample_en           : one-clock start strobe
//   wave0..2, voice_en  : per-voice table index, combined-waveform enable
//   rom                 : table read bus (master side)
//   out0..2, done       : registered results, one-clock update pulse
//   busy                : high whenever not IDLE
//   overrun, overrun_clr: sticky dropped-strobe flag and its clear
module sid_wave_arbiter
  import sid_pkg::*;
#(
  parameter int IDX_W = 12,
  parameter int DAT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  sample_en,
  input  logic [IDX_W-1:0]      wave0,
  input  logic [IDX_W-1:0]      wave1,
  input  logic [IDX_W-1:0]      wave2,
  input  logic [NUM_VOICES-1:0] voice_en,
  sid_wave_arbiter_if.master    rom,
  output logic [DAT_W-1:0]      out0,
  output logic [DAT_W-1:0]      out1,
  output logic [DAT_W-1:0]      out2,
  output logic                  done,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  state_t                state, state_nxt;
  logic                  pending, pending_nxt;
  logic                  start;
  logic                  ovr_set;
  logic [IDX_W-1:0]      snap0, snap1, snap2;
  logic [NUM_VOICES-1:0] snap_en;
  logic [DAT_W-1:0]      hold0, hold1, hold2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    start       = 1'b0;
    ovr_set     = 1'b0;
    case (state)
      IDLE: begin
        if (sample_en) begin
          start     = 1'b1;
          state_nxt = S0;
        end
      end
      S0, S1, S2: begin
        state_nxt = (state == S0) ? S1 : (state == S1) ? S2 : S3;
        // One strobe can wait for the round to finish; any further one is lost.
        if (sample_en) begin
          if (pending) ovr_set     = 1'b1;
          else         pending_nxt = 1'b1;
        end
      end
      S3: begin
        if (pending || sample_en) begin
          start     = 1'b1;
          state_nxt = S0;
          // A strobe landing on the pending start becomes the next pending one.
          pending_nxt = pending & sample_en;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every slot reads the table whatever voice_en says, so the schedule never moves.
  always_comb begin
    case (state)
      S0:      rom.rom_addr = snap0;
      S1:      rom.rom_addr = snap1;
      default: rom.rom_addr = snap2;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap0   <= '0;
      snap1   <= '0;
      snap2   <= '0;
      snap_en <= '0;
      hold0   <= '0;
      hold1   <= '0;
      hold2   <= '0;
      out0    <= '0;
      out1    <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= (state == S3);
      if (ovr_set)          overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
      if (start) begin
        snap0   <= wave0;
        snap1   <= wave1;
        snap2   <= wave2;
        snap_en <= voice_en;
      end
      case (state)
        S1: hold0 <= rom.rom_data;
        S2: hold1 <= rom.rom_data;
        S3: begin
          // Voice 2's data arrives on the update edge itself, so its hold
          // register doubles as the out2 register and is gated as it loads.
          hold2 <= snap_en[2] ? rom.rom_data : '0;
          out0  <= snap_en[0] ? hold0 : '0;
          out1  <= snap_en[1] ? hold1 : '0;
        end
        default: ;
      endcase
    end
  end

  assign out2 = hold2;
  assign busy = (state != IDLE);

endmodule
